// File: rtl/pwm_rgb_capture.sv
// Recovers an RGB565 colour from three LED PWM streams by counting high samples per frame.
// Optional macro PWM_CAPTURE_SYNC_EN adds a two-flop synchronizer on each LED input.
module pwm_rgb_capture #(
  parameter int unsigned FRAME_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rLED,
  input  logic        gLED,
  input  logic        bLED,
  output logic [15:0] colorOut,
  output logic        colorValid,
  output logic        colorChanged
);

  localparam int unsigned CntW = FRAME_LOG2 + 1;

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                state_q;
  logic [FRAME_LOG2-1:0] frame_q;
  logic [CntW-1:0]       r_cnt_q, g_cnt_q, b_cnt_q;
  logic [CntW-1:0]       r_cnt_d, g_cnt_d, b_cnt_d;
  logic [FRAME_LOG2-1:0] r_sat, g_sat, b_sat;
  logic [15:0]           color_d;
  logic [2:0]            led_smp;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // Held clear in IDLE so the first two samples of a fresh frame read as 0.
  always_ff @(posedge clk) begin
    if (rst || (state_q == StIdle)) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {rLED, gLED, bLED};
      sync2_q <= sync1_q;
    end
  end

  assign led_smp = sync2_q;
`else
  assign led_smp = {rLED, gLED, bLED};
`endif

  function automatic logic [FRAME_LOG2-1:0] saturate(input logic [CntW-1:0] cnt);
    return cnt[FRAME_LOG2] ? '1 : cnt[FRAME_LOG2-1:0];
  endfunction

  always_comb begin
    r_cnt_d = r_cnt_q + {{FRAME_LOG2{1'b0}}, led_smp[2]};
    g_cnt_d = g_cnt_q + {{FRAME_LOG2{1'b0}}, led_smp[1]};
    b_cnt_d = b_cnt_q + {{FRAME_LOG2{1'b0}}, led_smp[0]};
    r_sat   = saturate(r_cnt_d);
    g_sat   = saturate(g_cnt_d);
    b_sat   = saturate(b_cnt_d);
    color_d = {r_sat[FRAME_LOG2-1 -: 5], g_sat[FRAME_LOG2-1 -: 6], b_sat[FRAME_LOG2-1 -: 5]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_q      <= '0;
      r_cnt_q      <= '0;
      g_cnt_q      <= '0;
      b_cnt_q      <= '0;
      colorOut     <= 16'h0000;
      colorValid   <= 1'b0;
      colorChanged <= 1'b0;
    end else begin
      colorValid   <= 1'b0;
      colorChanged <= 1'b0;
      case (state_q)
        StIdle: begin
          frame_q <= '0;
          r_cnt_q <= '0;
          g_cnt_q <= '0;
          b_cnt_q <= '0;
          if (en) state_q <= StMeasure;
        end
        StMeasure: begin
          if (!en) begin
            // Abort wins over a coincident frame end; partial counts are dropped.
            state_q <= StIdle;
            frame_q <= '0;
            r_cnt_q <= '0;
            g_cnt_q <= '0;
            b_cnt_q <= '0;
          end else if (&frame_q) begin
            colorOut     <= color_d;
            colorValid   <= 1'b1;
            colorChanged <= (color_d != colorOut);
            frame_q      <= '0;
            r_cnt_q      <= '0;
            g_cnt_q      <= '0;
            b_cnt_q      <= '0;
          end else begin
            frame_q <= frame_q + 1'b1;
            r_cnt_q <= r_cnt_d;
            g_cnt_q <= g_cnt_d;
            b_cnt_q <= b_cnt_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/pwm_rgb_capture.md
PWM_RGB_CAPTURE -- requirements
Module: pwm_rgb_capture

Interface
REQ-001 Parameter FRAME_LOG2, default 6, log2 of the measurement frame length in clocks; legal range 6..12.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port en  input  1  capture enable, level-sensitive.
REQ-005 Port rLED  input  1  red PWM stream from the LED driver.
REQ-006 Port gLED  input  1  green PWM stream from the LED driver.
REQ-007 Port bLED  input  1  blue PWM stream from the LED driver.
REQ-008 Port colorOut  output  16  reconstructed RGB565 value: [15:11] red, [10:5] green, [4:0] blue.
REQ-009 Port colorValid  output  1  one-cycle pulse when colorOut is updated.
REQ-010 Port colorChanged  output  1  one-cycle pulse, coincident with colorValid, when the new colorOut differs from the previous colorOut.

Function
REQ-011 The block SHALL implement two states, IDLE and MEASURE.
REQ-012 IDLE -> MEASURE on the first clock with en=1; the frame counter and the three high-counters SHALL be 0 on entry.
REQ-013 In MEASURE, each clock SHALL sample rLED/gLED/bLED and increment the matching high-counter when the sampled bit is 1.
REQ-014 A frame SHALL be exactly 2^FRAME_LOG2 samples, counted by a FRAME_LOG2-bit frame counter that wraps to 0 after its last sample.
REQ-015 High-counters SHALL be FRAME_LOG2+1 bits wide; at frame end each count SHALL be saturated to 2^FRAME_LOG2-1.
REQ-016 Scaling: green = top 6 bits of the saturated count; red and blue = top 5 bits of their saturated counts.
REQ-017 On the clock edge that takes the last sample of a frame, including that sample, colorOut SHALL load the scaled values and colorValid SHALL assert for exactly one cycle.
REQ-018 colorChanged SHALL assert on that same edge only if the new colorOut differs from the value it replaces.
REQ-019 The next frame SHALL begin on the following clock with counters cleared, with no gap cycle, so the valid period is exactly 2^FRAME_LOG2 clocks.
REQ-020 en=0 during MEASURE SHALL abort the frame and return to IDLE on that edge: the partial counts are discarded, and colorValid is not pulsed.
REQ-021 colorOut SHALL hold its last published value in IDLE and throughout MEASURE.
REQ-022 If en deasserts on the same clock as the last sample, the abort SHALL take priority and no publish SHALL occur.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, clear all counters, colorOut=16'h0000, colorValid=0, colorChanged=0, and clear the synchronizer flops.
REQ-024 rst SHALL take priority over en and over any frame-end event; reset mid-frame discards the partial frame.
REQ-025 The first publish after reset SHALL compare against 16'h0000 for colorChanged.

Configuration
REQ-026 With macro PWM_CAPTURE_SYNC_EN defined, each LED input SHALL pass through a two-flop synchronizer before sampling.
REQ-027 With the synchronizer compiled in, the first two samples of a frame after leaving IDLE SHALL be treated as 0, and the sampling pipeline SHALL add 2 cycles of input-to-count latency while the frame timing is unchanged.
REQ-028 Without PWM_CAPTURE_SYNC_EN, inputs SHALL be sampled directly with zero added latency.

Verification (FRAME_LOG2=6, macro undefined unless stated)
REQ-029 rst 1 cycle, en=1, all LEDs held 1 for 64 clocks -> colorValid pulses at sample 64, colorOut=16'hFFFF, colorChanged=1.
REQ-030 All LEDs held 0 for one frame after reset -> colorOut=16'h0000, colorValid=1, colorChanged=0.
REQ-031 rLED high 32 of 64 clocks, gLED high 16, bLED high 2 -> colorOut={5'd16,6'd16,5'd1}=16'h8201.
REQ-032 Identical stimulus over two consecutive frames -> colorValid pulses 64 clocks apart; colorChanged=1 on the first pulse only.
REQ-033 en dropped at sample 40, raised again 10 clocks later -> no colorValid at the aborted frame end; the next pulse occurs 64 clocks after en rises; colorOut holds its prior value in between.
REQ-034 rst asserted at sample 50 with LEDs high -> colorOut=0 on the next edge, no colorValid; with PWM_CAPTURE_SYNC_EN defined and LEDs held 1, the first frame yields count 62 -> colorOut={5'd31,6'd62,5'd31}=16'hFFDF.
